mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped responder on the single-cycle core's data port (WE/A/WD/RD), sitting beside data memory.
//  Core stores bytes to a TX FIFO; an 8N1 serial shifter drains the FIFO onto a UART tx line.
//  Core polls status/level registers by load. The top-level muxes RD onto load data when sel=1.
// PARAMETERS
//  BASE_ADDR    32'h0000_1000  16-byte aligned base of the register window
//  FIFO_DEPTH   8              TX FIFO entries; power of 2, >=2
//  DEFAULT_DIV  16'd868        reset value of DIVISOR (clocks per bit; 100 MHz / 115200)
// PORTS
//  clk    in   1   single clock, rising edge
//  rst_n  in   1   asynchronous, active-low reset
//  WE     in   1   store strobe from core, sampled at posedge clk
//  A      in   32  byte address from core ALU result
//  WD     in   32  store data from core
//  RD     out  32  load data, combinational from A
//  sel    out  1   combinational: A[31:4]==BASE_ADDR[31:4]
//  tx     out  1   serial output, idle high
//  busy   out  1   shifter not IDLE
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset (async, immediate): tx=1, busy=0, FIFO empty, overflow=0, DIVISOR=DEFAULT_DIV, FSM=IDLE.
//  A reset mid-frame aborts the frame; tx goes high immediately.
//  Decode: match on A[31:4]; A[3:2] picks the register; A[1:0] ignored.
//  Decode miss: RD=0, sel=0, writes ignored.
//  Register map:
//   0x0 TXDATA  W: push WD[7:0]; reads 0.
//   0x4 STATUS  R: [0]full [1]empty [2]busy [3]overflow, rest 0. W: WD[3]=1 clears overflow.
//   0x8 DIVISOR R/W: [15:0]; a write of 0 stores 1; RD[31:16]=0.
//   0xC LEVEL   R: FIFO count, zero-extended; writes ignored.
//  Push rule:
//   - Write to TXDATA while full with no same-cycle pop: byte dropped, overflow sticky set.
//   - Push with same-cycle pop is always accepted; count is unchanged.
//   - Overflow set and clear in the same cycle cannot occur (different addresses).
//  FSM: IDLE -> START -> DATA -> STOP.
//   - IDLE: tx=1. If FIFO non-empty: pop head into shift reg, latch DIVISOR into bit timer, go START.
//   - START: tx=0 for DIV clocks.
//   - DATA: 8 bits LSB first, DIV clocks each; 3-bit index counter.
//   - STOP: tx=1 for DIV clocks. On the last clock, FIFO non-empty -> pop and go START directly
//     (back-to-back, no idle gap); else go IDLE.
//  Timing and width rules:
//   - Frame = 10*DIV clocks.
//   - DIVISOR changes mid-frame take effect at the next frame only.
//   - Latency: TXDATA write at edge k into an empty FIFO, IDLE -> FSM leaves IDLE at edge k+1;
//     tx low from k+1 to k+1+DIV.
//   - Counters: bit timer 16 bits, counts DIV-1 down to 0.
//   - FIFO pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
//  Outputs: tx and busy are registered (no glitches); RD and sel are combinational.
// TESTING
//  1. Reset: rst_n low mid-frame -> tx=1 and busy=0 at once; after release, LEVEL=0, STATUS=0x2,
//     DIVISOR=868.
//  2. Single byte: DIV=4, write 0xA5 to TXDATA -> tx low 4 clk, then bits 1,0,1,0,0,1,0,1 (4 clk each),
//     stop high; busy=0 after 40 clk.
//  3. Back-to-back: DIV=2, write 0x01, 0x80 on consecutive cycles -> second start bit directly follows
//     first stop; 40 clk total; LEVEL reads 1 during frame 1.
//  4. Overflow: DIV=100, write 10 bytes with FIFO_DEPTH=8 -> first byte popped into shifter, 8 queued,
//     10th dropped, STATUS[3]=1; write 0x8 to STATUS -> STATUS[3]=0.
//  5. Push+pop while full: full FIFO, write TXDATA on the cycle the STOP->START pop occurs -> accepted,
//     LEVEL stays 8, overflow stays 0.
//  6. Decode/divisor: write to BASE+0x10 -> no effect, sel=0, RD=0; write 0 to DIVISOR -> reads 1;
//     DIVISOR write mid-frame -> current frame keeps old bit time.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: the core stores bytes into a TX FIFO, and a serial shifter drains them onto tx.
// Register access is combinational on RD; tx/busy are registered. Back-to-back frames are sent without an idle gap.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        sel,
  output logic        tx,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [15:0]     timer_q, timer_d;
  logic [15:0]     div_lat_q, div_lat_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic [15:0]     div_q, div_d;
  logic            ovf_q, ovf_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;

  logic            full, empty, pop, push_ok, start_frame;
  logic            wr_txdata, wr_status, wr_div;
  logic            unused_bits;

  assign unused_bits = ^{WD[31:16], A[1:0]};

  assign sel       = (A[31:4] == BASE_ADDR[31:4]);
  assign wr_txdata = WE && sel && (A[3:2] == 2'd0);
  assign wr_status = WE && sel && (A[3:2] == 2'd1);
  assign wr_div    = WE && sel && (A[3:2] == 2'd2);

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign push_ok = wr_txdata && (!full || pop);

  always_comb begin
    ovf_d = ovf_q;
    if (wr_txdata && full && !pop) ovf_d = 1'b1;
    else if (wr_status && WD[3])   ovf_d = 1'b0;
  end

  always_comb begin
    div_d = div_q;
    if (wr_div) div_d = (WD[15:0] == 16'd0) ? 16'd1 : WD[15:0];
  end

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push_ok) count_d = count_q - CW'(1);
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    div_lat_d   = div_lat_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    start_frame = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!empty) start_frame = 1'b1;
      end
      START: begin
        if (timer_q == 16'd0) begin
          state_d   = DATA;
          timer_d   = div_lat_q - 16'd1;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      DATA: begin
        if (timer_q == 16'd0) begin
          timer_d = div_lat_q - 16'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      STOP: begin
        if (timer_q == 16'd0) begin
          if (!empty) begin
            start_frame = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The divisor is sampled once per frame so mid-frame writes only affect the next frame.
    if (start_frame) begin
      state_d   = START;
      shift_d   = mem_q[rd_ptr_q];
      div_lat_d = div_q;
      timer_d   = div_q - 16'd1;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
    end
  end

  assign pop = start_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      div_lat_q <= DEFAULT_DIV;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      div_q     <= DEFAULT_DIV;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      div_lat_q <= div_lat_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      div_q     <= div_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= WD[7:0];
  end

  always_comb begin
    RD = '0;
    if (sel) begin
      case (A[3:2])
        2'd1:    RD = {28'd0, ovf_q, busy_q, empty, full};
        2'd2:    RD = {16'd0, div_q};
        2'd3:    RD = {{(32-CW){1'b0}}, count_q};
        default: RD = '0;
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame timing, FIFO full/overflow and reset behaviour.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] R_TX = BASE + 32'h0;
  localparam logic [31:0] R_ST = BASE + 32'h4;
  localparam logic [31:0] R_DV = BASE + 32'h8;
  localparam logic [31:0] R_LV = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        WE;
  logic [31:0] A, WD, RD;
  logic        sel, tx, busy;

  int total = 0;
  int bad   = 0;

  mmio_uart_tx dut (
    .clk  (clk),
    .rst_n(rst_n),
    .WE   (WE),
    .A    (A),
    .WD   (WD),
    .RD   (RD),
    .sel  (sel),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one store; returns at the negedge after the capturing posedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    WE = 1'b1; A = a; WD = d;
    @(negedge clk);
    WE = 1'b0; WD = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    A = a;
    #1;
    d = RD;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int n);
    if (n == 0) return 1'b0;
    if (n == 9) return 1'b1;
    return b[n-1];
  endfunction

  task automatic chk_frame(input string tag, input logic [7:0] b, input int div);
    for (int i = 0; i < 10*div; i++) begin
      check(tag, {31'd0, tx}, {31'd0, frame_bit(b, i/div)});
      step(1);
    end
  endtask

  initial begin
    logic [31:0] r;
    rst_n = 1'b0; WE = 1'b0; A = '0; WD = '0;
    step(2);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    step(1);
    rd(R_LV, r); check("rst_level", r, 32'd0);
    rd(R_ST, r); check("rst_status", r, 32'h2);
    rd(R_DV, r); check("rst_div", r, 32'd868);
    rd(R_TX, r); check("txdata_reads0", r, 32'd0);
    check("sel_hit", {31'd0, sel}, 32'd1);

    // Single byte 0xA5 at 4 clocks per bit.
    wr(R_DV, 32'd4);
    wr(R_TX, 32'hA5);
    check("lat_idle_tx", {31'd0, tx}, 32'd1);
    step(1);
    check("a5_busy", {31'd0, busy}, 32'd1);
    chk_frame("a5_tx", 8'hA5, 4);
    check("a5_done_busy", {31'd0, busy}, 32'd0);
    check("a5_done_tx", {31'd0, tx}, 32'd1);

    // Back-to-back frames, no idle gap between them.
    wr(R_DV, 32'd2);
    wr(R_TX, 32'h01);
    wr(R_TX, 32'h80);
    rd(R_LV, r); check("b2b_level", r, 32'd1);
    chk_frame("b2b_f1", 8'h01, 2);
    check("b2b_gap_busy", {31'd0, busy}, 32'd1);
    chk_frame("b2b_f2", 8'h80, 2);
    check("b2b_done_busy", {31'd0, busy}, 32'd0);

    // Decode miss and divisor zero clamp.
    wr(BASE + 32'h18, 32'd5);
    A = BASE + 32'h10; #1;
    check("miss_sel", {31'd0, sel}, 32'd0);
    check("miss_rd", RD, 32'd0);
    wr(BASE + 32'h10, 32'h77);
    rd(R_DV, r); check("miss_div_kept", r, 32'd2);
    rd(R_LV, r); check("miss_no_push", r, 32'd0);
    wr(R_DV, 32'h0001_0000);
    rd(R_DV, r); check("div_zero_is1", r, 32'd1);

    // Overflow: ten stores, one goes to the shifter, eight queue, last dropped.
    wr(R_DV, 32'd100);
    for (int i = 0; i < 10; i++) wr(R_TX, 32'h10 + i);
    rd(R_LV, r); check("ovf_level", r, 32'd8);
    rd(R_ST, r); check("ovf_status", r, 32'hD);
    wr(R_ST, 32'h7);
    rd(R_ST, r); check("ovf_noclr", r, 32'hD);
    wr(R_ST, 32'h8);
    rd(R_ST, r); check("ovf_clr", r, 32'h5);

    // Reset in the middle of a start bit.
    check("pre_rst_tx", {31'd0, tx}, 32'd0);
    rst_n = 1'b0; #1;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    rd(R_LV, r); check("midrst_level", r, 32'd0);
    rd(R_ST, r); check("midrst_status", r, 32'h2);
    rd(R_DV, r); check("midrst_div", r, 32'd868);

    // Push while full on the exact STOP->START pop cycle.
    wr(R_DV, 32'd2);
    for (int i = 0; i < 9; i++) wr(R_TX, 32'h20 + i);
    step(12);
    rd(R_LV, r); check("pp_pre_level", r, 32'd8);
    rd(R_ST, r); check("pp_pre_status", r, 32'h5);
    check("pp_pre_tx_stop", {31'd0, tx}, 32'd1);
    wr(R_TX, 32'h55);
    rd(R_LV, r); check("pp_level", r, 32'd8);
    rd(R_ST, r); check("pp_status", r, 32'h5);
    check("pp_start_tx", {31'd0, tx}, 32'd0);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);

    // Divisor written mid-frame only applies to the following frame.
    wr(R_DV, 32'd2);
    wr(R_TX, 32'h00);
    step(1);
    wr(R_DV, 32'd6);
    rd(R_DV, r); check("mid_div_read", r, 32'd6);
    step(17);
    check("mid_old_stop_tx", {31'd0, tx}, 32'd1);
    check("mid_old_stop_busy", {31'd0, busy}, 32'd1);
    step(2);
    check("mid_old_done", {31'd0, busy}, 32'd0);
    wr(R_TX, 32'hFF);
    step(6);
    check("new_div_start", {31'd0, tx}, 32'd0);
    step(1);
    check("new_div_bit0", {31'd0, tx}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
